fadd_accum_ctrl: RTL

FADD_ACCUM_CTRL -- requirements
Module: fadd_accum_ctrl

---
 rtl/fadd_accum_ctrl.sv | 70 +++++++
 1 files changed

// File: rtl/fadd_accum_ctrl.sv
// fadd_accum_ctrl: accumulates a packet of float beats through an external adder and presents the sum
module fadd_accum_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_data,
   input  logic             in_last,
   output logic [31:0]      fa_x1,
   output logic [31:0]      fa_x2,
   input  logic [31:0]      fa_y,
   input  logic             fa_ovf,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_data,
   output logic [CNT_W-1:0] out_count,
   output logic             out_ovf
);
   typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;
   state_t state_q, state_d;
   logic [31:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic ovf_q, ovf_d;
   logic accept;
   assign in_ready  = state_q != HOLD;
   assign accept    = in_valid && in_ready;
   assign fa_x1     = acc_q;
   assign fa_x2     = in_data;
   assign out_valid = state_q == HOLD;
   assign out_data  = out_valid ? acc_q : '0;
   assign out_count = out_valid ? cnt_q : '0;
   assign out_ovf   = out_valid && ovf_q;
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      case (state_q)
         IDLE, ACC: if (accept) begin
            state_d = in_last ? HOLD : ACC;
            // first beat bypasses the adder so its exact bits (including -0) survive
            acc_d   = state_q == IDLE ? in_data : fa_y;
            cnt_d   = state_q == IDLE ? CNT_W'(1) : (&cnt_q ? cnt_q : cnt_q + CNT_W'(1));
            ovf_d   = state_q == ACC && (ovf_q || fa_ovf);
         end
         HOLD: if (out_ready) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
      end
   end
endmodule
